conv33_output_arbiter: RTL and testbench
========================================

CONV33_OUTPUT_ARBITER -- requirements
Module: conv33_output_arbiter

Interface
REQ-001 Parameter OUT_WIDTH, default 32, is the width of one output word.
REQ-002 Parameter N_LANES, default 4, is the number of compute lanes; the legal range is 2..8.
REQ-003 Parameter PIX_PER_FRAME, default 676, is the number of words per frame; the legal range is 1..65535.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port start, input, 1 bit: single-cycle pulse that begins a frame.
REQ-007 Port lane_valid, input, N_LANES bits: per-lane word available.
REQ-008 Port lane_data, input, N_LANES*OUT_WIDTH bits: lane i occupies bits [i*OUT_WIDTH +: OUT_WIDTH].
REQ-009 Port lane_ready, output, N_LANES bits: per-lane accept; a transfer occurs when lane_valid[i] and lane_ready[i] are both high.
REQ-010 Port out_valid, output, 1 bit: output word valid.
REQ-011 Port out_data, output, OUT_WIDTH bits: output word.
REQ-012 Port out_lane, output, 3 bits: source lane index of out_data.
REQ-013 Port out_last, output, 1 bit: marks the final word of a frame.
REQ-014 Port out_ready, input, 1 bit: downstream accept.
REQ-015 Port frame_done, output, 1 bit: single-cycle pulse at the end of a frame.
REQ-016 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-018 IDLE SHALL move to RUN on start; start SHALL be ignored in RUN and in DRAIN.
REQ-019 RUN SHALL move to DRAIN in the cycle the frame's PIX_PER_FRAME-th word is loaded into the output register.
REQ-020 DRAIN SHALL move to IDLE on the out_valid and out_ready handshake of the out_last word.
REQ-021 frame_done SHALL pulse high for exactly one cycle, in the cycle after the DRAIN-to-IDLE transition.
REQ-022 The output register SHALL hold a single word; load_en SHALL be true when the state is RUN, any lane_valid bit is high, and either out_valid is low or out_ready is high.
REQ-023 Lane selection SHALL be round-robin, searching from lane rr_ptr+1 upward with wrap to lane 0; the first valid lane found is granted.
REQ-024 On each load, rr_ptr SHALL update to the granted lane.
REQ-025 lane_ready SHALL be combinational and one-hot for the granted lane when load_en is true; otherwise it SHALL be all zeros.
REQ-026 lane_ready SHALL be all zeros in IDLE and in DRAIN.
REQ-027 On load, out_data, out_lane and out_valid=1 SHALL register with one cycle of latency from the lane handshake.
REQ-028 On load, out_last SHALL be set to 1 when pix_cnt equals PIX_PER_FRAME-1, and to 0 otherwise.
REQ-029 While out_valid is high and out_ready is low, out_data, out_lane and out_last SHALL be held stable.
REQ-030 out_valid SHALL clear on a handshake if there is no simultaneous load.
REQ-031 A simultaneous handshake and load SHALL replace the word with no bubble, giving one word per cycle at full throughput.
REQ-032 pix_cnt SHALL be a 16-bit counter that increments on each load.
REQ-033 pix_cnt SHALL wrap to 0 on the load of the last word.
REQ-034 When PIX_PER_FRAME is 1, the first load SHALL set out_last and move the FSM directly to DRAIN.
REQ-035 A lane left un-granted SHALL keep its data; a lane that is continuously valid SHALL be granted within N_LANES loads.
REQ-036 Lanes SHALL hold lane_valid and lane_data until their handshake; the block does not buffer per lane.

Reset
REQ-037 While rst is high on a clock edge, the state SHALL be IDLE, rr_ptr SHALL be N_LANES-1 (so lane 0 has first priority), and pix_cnt SHALL be 0.
REQ-038 While rst is high on a clock edge, out_valid, out_last, frame_done and busy SHALL be 0.
REQ-039 While rst is high on a clock edge, out_data and out_lane SHALL be 0, and lane_ready SHALL be 0.
REQ-040 Reset asserted mid-frame SHALL discard the held word and the count; after rst is released, no grant SHALL occur before a new start.

Verification
REQ-041 With PIX_PER_FRAME=4, start, and only lane 2 valid with data 0xA0..0xA3, out_ready=1: expect four words on consecutive cycles, out_lane=2, out_last only on 0xA3, and frame_done one cycle after the 0xA3 handshake.
REQ-042 With all 4 lanes continuously valid and out_ready=1 after reset: expect out_lane sequence 0,1,2,3,0,1,... with no idle cycles.
REQ-043 With out_ready held low for 5 cycles while a word is valid: expect out_data stable, lane_ready all zeros, and no word lost or duplicated after out_ready returns high.
REQ-044 With start pulsed while busy=1: expect no change to the state, pix_cnt or the output.
REQ-045 With rst asserted after 2 of 4 words, then a new start: expect the first word's out_last=0, and out_last on the 4th word of the new frame.
REQ-046 With PIX_PER_FRAME=1 and lane 1 valid: expect one word with out_last=1, the state going to DRAIN, and lane_ready all zeros until IDLE is re-entered and a new start is given.

Source files
------------

// File: rtl/conv33_output_arbiter.sv
// Round-robin arbiter that merges N_LANES compute-lane streams into one output
// stream, framing PIX_PER_FRAME words per start pulse with out_last/frame_done.
module conv33_output_arbiter #(
  parameter int OUT_WIDTH     = 32,
  parameter int N_LANES       = 4,
  parameter int PIX_PER_FRAME = 676
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_LANES-1:0]           lane_valid,
  input  logic [N_LANES*OUT_WIDTH-1:0] lane_data,
  output logic [N_LANES-1:0]           lane_ready,
  output logic                         out_valid,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic [2:0]                   out_lane,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         frame_done,
  output logic                         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [15:0] LAST_CNT = 16'(PIX_PER_FRAME - 1);
  localparam logic [2:0]  RR_INIT  = 3'(N_LANES - 1);

  state_t                 state, state_nxt;
  logic [2:0]             rr_ptr;
  logic [15:0]            pix_cnt;
  logic [7:0]             valid_pad;
  logic [OUT_WIDTH-1:0]   lane_word [8];
  logic [2:0]             grant;
  logic                   grant_found;
  logic                   load_en;
  logic                   last_pix;
  logic                   drain_done;
  logic [7:0]             ready_pad;

  // Lanes are padded out to 8 so the 3-bit grant index always selects in range.
  assign valid_pad = 8'(lane_valid);

  for (genvar g = 0; g < 8; g++) begin : g_unpack
    if (g < N_LANES) begin : g_lane
      assign lane_word[g] = lane_data[g*OUT_WIDTH +: OUT_WIDTH];
    end else begin : g_pad
      assign lane_word[g] = '0;
    end
  end

  always_comb begin
    logic [2:0] idx;
    grant       = '0;
    grant_found = 1'b0;
    idx         = '0;
    for (int k = 1; k <= N_LANES; k++) begin
      idx = 3'((int'(rr_ptr) + k) % N_LANES);
      if (!grant_found && valid_pad[idx]) begin
        grant       = idx;
        grant_found = 1'b1;
      end
    end
  end

  // Reset gates the grant so no lane sees a handshake while rst is high.
  assign load_en    = !rst && (state == RUN) && grant_found && (!out_valid || out_ready);
  assign last_pix   = (pix_cnt == LAST_CNT);
  assign drain_done = (state == DRAIN) && out_valid && out_ready && out_last;
  assign ready_pad  = 8'b1 << grant;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (load_en && last_pix) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    lane_ready = '0;
    if (load_en) lane_ready = ready_pad[N_LANES-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= RR_INIT;
      pix_cnt    <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      out_lane   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= drain_done;
      if (load_en) begin
        out_data  <= lane_word[grant];
        out_lane  <= grant;
        out_valid <= 1'b1;
        out_last  <= last_pix;
        rr_ptr    <= grant;
        pix_cnt   <= last_pix ? 16'd0 : pix_cnt + 16'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv33_output_arbiter.sv
// Directed bench for conv33_output_arbiter: a 4-word-frame instance driven by
// simple per-lane sources, plus a single-word-frame instance.
module tb_conv33_output_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   lane_valid;
  logic [127:0] lane_data;
  logic [3:0]   lane_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [2:0]   out_lane;
  logic         out_last;
  logic         out_ready;
  logic         frame_done;
  logic         busy;

  logic         start_b;
  logic [3:0]   lv_b;
  logic [127:0] ld_b;
  logic [3:0]   lr_b;
  logic         ov_b;
  logic [31:0]  od_b;
  logic [2:0]   ol_b;
  logic         olast_b;
  logic         or_b;
  logic         fd_b;
  logic         busy_b;

  int checks = 0;
  int errors = 0;

  logic [3:0]  src_on = '0;
  logic [31:0] src_cnt  [4] = '{default: 32'd0};
  logic [31:0] src_lim  [4] = '{default: 32'd0};
  logic [31:0] src_base [4] = '{default: 32'd0};

  always #5 clk = ~clk;

  conv33_output_arbiter #(.OUT_WIDTH(32), .N_LANES(4), .PIX_PER_FRAME(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .lane_valid(lane_valid), .lane_data(lane_data),
    .lane_ready(lane_ready), .out_valid(out_valid), .out_data(out_data), .out_lane(out_lane),
    .out_last(out_last), .out_ready(out_ready), .frame_done(frame_done), .busy(busy)
  );

  conv33_output_arbiter #(.OUT_WIDTH(32), .N_LANES(4), .PIX_PER_FRAME(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_b), .lane_valid(lv_b), .lane_data(ld_b),
    .lane_ready(lr_b), .out_valid(ov_b), .out_data(od_b), .out_lane(ol_b),
    .out_last(olast_b), .out_ready(or_b), .frame_done(fd_b), .busy(busy_b)
  );

  // Lane sources: each holds its word until the handshake, then presents the next.
  always_comb begin
    lane_valid = '0;
    lane_data  = '0;
    for (int i = 0; i < 4; i++) begin
      lane_valid[i]         = src_on[i] && (src_cnt[i] < src_lim[i]);
      lane_data[i*32 +: 32] = src_base[i] + src_cnt[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (lane_valid[i] && lane_ready[i]) src_cnt[i] <= src_cnt[i] + 32'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic src_load(input int lane, input logic [31:0] first, input int n);
    src_base[lane] = first - src_cnt[lane];
    src_lim[lane]  = src_cnt[lane] + 32'(n);
    src_on[lane]   = 1'b1;
  endtask

  task automatic do_reset();
    src_on    = '0;
    start     = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) src_load(i, 32'h10 * i, 8);
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %0b want 0", out_last); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %0b want 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h want 0", out_data); end
    checks++; if (out_lane !== 3'd0) begin errors++; $display("FAIL rst_out_lane got %0d want 0", out_lane); end
    checks++; if (lane_ready !== 4'b0000) begin errors++; $display("FAIL rst_lane_ready got %b want 0000", lane_ready); end
    rst = 1'b0;
    tick();
    checks++; if (lane_ready !== 4'b0000) begin errors++; $display("FAIL idle_lane_ready got %b want 0000", lane_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got %0b want 0", out_valid); end
    src_on = '0;
  endtask

  task automatic test_single_lane();
    do_reset();
    src_load(2, 32'hA0, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (lane_ready !== 4'b0100) begin errors++; $display("FAIL sl_first_ready got %b want 0100", lane_ready); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hA0 + 32'(k) || out_lane !== 3'd2)
        begin errors++; $display("FAIL sl_word%0d got v%0b %h l%0d want v1 %h l2", k, out_valid, out_data, out_lane, 32'hA0 + 32'(k)); end
      checks++; if (out_last !== (k == 3)) begin errors++; $display("FAIL sl_last%0d got %0b want %0b", k, out_last, (k == 3)); end
      checks++; if (frame_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL sl_busy%0d got fd%0b b%0b want fd0 b1", k, frame_done, busy); end
    end
    checks++; if (lane_ready !== 4'b0000) begin errors++; $display("FAIL sl_drain_ready got %b want 0000", lane_ready); end
    tick();
    checks++; if (frame_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL sl_done got fd%0b b%0b v%0b want fd1 b0 v0", frame_done, busy, out_valid); end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL sl_done_pulse got %0b want 0", frame_done); end
    src_on = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) src_load(i, 32'h100 * (i + 1), 20);
    for (int f = 0; f < 2; f++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 0; j < 4; j++) begin
        tick();
        checks++; if (out_valid !== 1'b1 || out_lane !== 3'(j) || out_data !== 32'h100 * (j + 1) + 32'(f))
          begin errors++; $display("FAIL rr_f%0d_w%0d got v%0b l%0d %h want v1 l%0d %h", f, j, out_valid, out_lane, out_data, j, 32'h100 * (j + 1) + 32'(f)); end
      end
      tick();
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL rr_done%0d got %0b want 1", f, frame_done); end
    end
    src_on = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    src_load(1, 32'h50, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    out_ready = 1'b0;
    #1;
    checks++; if (lane_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready got %b want 0000", lane_ready); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h50 || lane_ready !== 4'b0000)
        begin errors++; $display("FAIL bp_hold%0d got v%0b %h r%b want v1 50 r0000", k, out_valid, out_data, lane_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (lane_ready !== 4'b0010) begin errors++; $display("FAIL bp_resume_ready got %b want 0010", lane_ready); end
    for (int k = 1; k < 4; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h50 + 32'(k) || out_last !== (k == 3))
        begin errors++; $display("FAIL bp_word%0d got v%0b %h last%0b want v1 %h last%0b", k, out_valid, out_data, out_last, 32'h50 + 32'(k), (k == 3)); end
    end
    tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL bp_done got %0b want 1", frame_done); end
    src_on = '0;
  endtask

  task automatic test_start_ignored();
    do_reset();
    src_load(3, 32'hC0, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    out_ready = 1'b0;
    tick();
    checks++; if (out_data !== 32'hC0 || out_lane !== 3'd3 || out_valid !== 1'b1 || out_last !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL si_run got %h l%0d v%0b last%0b b%0b want C0 l3 v1 last0 b1", out_data, out_lane, out_valid, out_last, busy); end
    start = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      checks++; if (out_data !== 32'hC0 + 32'(k) || out_last !== (k == 3))
        begin errors++; $display("FAIL si_word%0d got %h last%0b want %h last%0b", k, out_data, out_last, 32'hC0 + 32'(k), (k == 3)); end
    end
    checks++; if (lane_ready !== 4'b0000) begin errors++; $display("FAIL si_drain_ready got %b want 0000", lane_ready); end
    start = 1'b1;
    out_ready = 1'b0;
    tick();
    checks++; if (out_data !== 32'hC3 || out_valid !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL si_drain got %h v%0b b%0b want C3 v1 b1", out_data, out_valid, busy); end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (frame_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL si_done got fd%0b b%0b want fd1 b0", frame_done, busy); end
    tick();
    checks++; if (busy !== 1'b0 || lane_ready !== 4'b0000)
      begin errors++; $display("FAIL si_idle got b%0b r%b want b0 r0000", busy, lane_ready); end
    src_on = '0;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    src_load(0, 32'hD0, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++; if (out_data !== 32'hD1) begin errors++; $display("FAIL mr_pre got %h want D1", out_data); end
    rst = 1'b1;
    #1;
    checks++; if (lane_ready !== 4'b0000) begin errors++; $display("FAIL mr_rst_ready got %b want 0000", lane_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0)
      begin errors++; $display("FAIL mr_rst got v%0b b%0b %h want v0 b0 0", out_valid, busy, out_data); end
    rst = 1'b0;
    tick();
    checks++; if (lane_ready !== 4'b0000 || out_valid !== 1'b0)
      begin errors++; $display("FAIL mr_nogrant got r%b v%0b want r0000 v0", lane_ready, out_valid); end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hD2 + 32'(k) || out_last !== (k == 3))
        begin errors++; $display("FAIL mr_word%0d got v%0b %h last%0b want v1 %h last%0b", k, out_valid, out_data, out_last, 32'hD2 + 32'(k), (k == 3)); end
    end
    tick();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL mr_done got %0b want 1", frame_done); end
    src_on = '0;
  endtask

  task automatic test_ppf1();
    do_reset();
    lv_b  = 4'b0010;
    ld_b  = {32'h0, 32'h0, 32'h77, 32'h0};
    or_b  = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    checks++; if (lr_b !== 4'b0010) begin errors++; $display("FAIL p1_ready got %b want 0010", lr_b); end
    tick();
    checks++; if (ov_b !== 1'b1 || od_b !== 32'h77 || ol_b !== 3'd1 || olast_b !== 1'b1)
      begin errors++; $display("FAIL p1_word got v%0b %h l%0d last%0b want v1 77 l1 last1", ov_b, od_b, ol_b, olast_b); end
    checks++; if (busy_b !== 1'b1 || lr_b !== 4'b0000) begin errors++; $display("FAIL p1_drain got b%0b r%b want b1 r0000", busy_b, lr_b); end
    or_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (lr_b !== 4'b0000 || ov_b !== 1'b1 || busy_b !== 1'b1)
        begin errors++; $display("FAIL p1_hold%0d got r%b v%0b b%0b want r0000 v1 b1", k, lr_b, ov_b, busy_b); end
    end
    or_b = 1'b1;
    tick();
    checks++; if (fd_b !== 1'b1 || busy_b !== 1'b0 || ov_b !== 1'b0 || lr_b !== 4'b0000)
      begin errors++; $display("FAIL p1_done got fd%0b b%0b v%0b r%b want fd1 b0 v0 r0000", fd_b, busy_b, ov_b, lr_b); end
    tick();
    checks++; if (lr_b !== 4'b0000 || fd_b !== 1'b0) begin errors++; $display("FAIL p1_idle got r%b fd%0b want r0000 fd0", lr_b, fd_b); end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    checks++; if (lr_b !== 4'b0010) begin errors++; $display("FAIL p1_restart got %b want 0010", lr_b); end
    tick();
    lv_b = '0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    start_b   = 1'b0;
    lv_b      = '0;
    ld_b      = '0;
    or_b      = 1'b1;
    test_reset();
    test_single_lane();
    test_round_robin();
    test_backpressure();
    test_start_ignored();
    test_reset_midframe();
    test_ppf1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
